// File: rtl/rfphoenix_ifq_pkg.sv
// Shared instruction-word types and opcode constants for the rfPhoenix
// fetch/decode path.
package rfphoenix_ifq_pkg;

    typedef logic [39:0] Instruction;
    typedef logic [39:0] Postfix;
    typedef logic [5:0]  opcode_t;

    // Opcode occupies the low six bits of every 40-bit word.
    localparam opcode_t OPC_ADD  = 6'h02;
    localparam opcode_t OPC_ADDI = 6'h04;
    localparam opcode_t OPC_XOR  = 6'h0A;
    localparam opcode_t OPC_PFX  = 6'h3F;

    // All-zero word; its opcode is not OPC_PFX, so it never reads as a postfix.
    localparam Postfix NULL_PFX = '0;

    function automatic logic is_pfx(input Instruction w);
        return w[5:0] == OPC_PFX;
    endfunction

endpackage

// File: rtl/rfphoenix_ifq.sv
// Instruction fetch queue: buffers raw fetched words and pairs each
// instruction with an immediately following postfix before decode.
module rfphoenix_ifq
    import rfphoenix_ifq_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PCW   = 32
) (
    input  logic           rst_ni,
    input  logic           clk_i,
    input  logic           flush_i,
    input  Instruction     word_i,
    input  logic [PCW-1:0] pc_i,
    input  logic           valid_i,
    output logic           ready_o,
    output Instruction     ir_o,
    output Postfix         pfx_o,
    output logic [PCW-1:0] pc_o,
    output logic           valid_o,
    input  logic           ready_i,
    output logic           orphan_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          orphan_q, orphan_d;

    Instruction     word_mem [DEPTH];
    logic [PCW-1:0] pc_mem   [DEPTH];

    logic [AW-1:0] head_nxt;
    Instruction    head_word;
    Instruction    next_word;
    logic          head_pfx;
    logic          next_pfx;
    logic          push;
    logic [1:0]    pop_n;

    // Head/tail pointers, occupancy and orphan pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
            orphan_q <= 1'b0;
        end else begin
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
            orphan_q <= orphan_d;
        end
    end

    // Storage is not reset; contents are meaningless while count is zero.
    always_ff @(posedge clk_i) begin
        if (push) begin
            word_mem[tail_q] <= word_i;
            pc_mem[tail_q]   <= pc_i;
        end
    end

    // Pairing, output selection, push/pop and next-state pointer arithmetic.
    always_comb begin
        head_nxt  = head_q + 1'b1;
        head_word = word_mem[head_q];
        next_word = word_mem[head_nxt];
        head_pfx  = is_pfx(head_word);
        next_pfx  = is_pfx(next_word);

        ready_o   = !flush_i && (count_q < CW'(DEPTH));
        valid_o   = !flush_i && (count_q >= CW'(2)) && !head_pfx;
        ir_o      = head_word;
        pc_o      = pc_mem[head_q];
        pfx_o     = next_pfx ? next_word : NULL_PFX;
        orphan_o  = orphan_q;

        push      = valid_i && ready_o;
        pop_n     = 2'd0;
        orphan_d  = 1'b0;

        if (!flush_i) begin
            if ((count_q != '0) && head_pfx) begin
                pop_n    = 2'd1;
                orphan_d = 1'b1;
            end else if (valid_o && ready_i) begin
                pop_n    = next_pfx ? 2'd2 : 2'd1;
            end
        end

        // Push slot uses the pre-pop tail; pop only moves head.
        if (flush_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + AW'(pop_n);
            tail_d  = tail_q + AW'(push);
            count_d = count_q + CW'(push) - CW'(pop_n);
        end
    end

endmodule

// File: tb/tb_rfphoenix_ifq.sv
// Directed self-checking bench for rfphoenix_ifq (DEPTH=4, PCW=32).
module tb_rfphoenix_ifq;
    import rfphoenix_ifq_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    Instruction  word;
    logic [31:0] pc;
    logic        vin;
    logic        rdy_out;
    Instruction  ir;
    Postfix      pfx;
    logic [31:0] pc_out;
    logic        vout;
    logic        rdy_in;
    logic        orphan;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    rfphoenix_ifq #(.DEPTH(4), .PCW(32)) dut (
        .rst_ni  (rst_n),
        .clk_i   (clk),
        .flush_i (flush),
        .word_i  (word),
        .pc_i    (pc),
        .valid_i (vin),
        .ready_o (rdy_out),
        .ir_o    (ir),
        .pfx_o   (pfx),
        .pc_o    (pc_out),
        .valid_o (vout),
        .ready_i (rdy_in),
        .orphan_o(orphan)
    );

    always #5 clk = ~clk;

    function automatic Instruction mk(input opcode_t opc, input logic [33:0] imm);
        return {imm, opc};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input Instruction w, input logic [31:0] a);
        word = w; pc = a; vin = 1'b1;
        step();
        vin = 1'b0;
    endtask

    task automatic do_flush();
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
    endtask

    Instruction w_addi, w_pfx, w_add, w_xor;

    initial begin
        w_addi = mk(OPC_ADDI, 34'h55);
        w_pfx  = mk(OPC_PFX, 34'h1234);
        w_add  = mk(OPC_ADD, 34'h11);
        w_xor  = mk(OPC_XOR, 34'h22);

        rst_n = 1'b0; flush = 1'b0; word = '0; pc = '0; vin = 1'b0; rdy_in = 1'b0;
        #12 rst_n = 1'b1;
        step();
        chk("rst_valid", 64'(vout), 64'd0);
        chk("rst_ready", 64'(rdy_out), 64'd1);
        chk("rst_count", 64'(dut.count_q), 64'd0);
        chk("rst_orphan", 64'(orphan), 64'd0);

        // Instruction + postfix pair, then a third word pushed while the pair pops.
        rdy_in = 1'b1;
        push_word(w_addi, 32'h100);
        chk("lone_valid", 64'(vout), 64'd0);
        push_word(w_pfx, 32'h105);
        word = w_addi; pc = 32'h10A; vin = 1'b1;
        #1;
        chk("pair_valid", 64'(vout), 64'd1);
        chk("pair_ir", 64'(ir), 64'(w_addi));
        chk("pair_pfx", 64'(pfx), 64'(w_pfx));
        chk("pair_pc", 64'(pc_out), 64'h100);
        step();
        vin = 1'b0;
        #1;
        chk("pair_count", 64'(dut.count_q), 64'd1);
        chk("pair_after_valid", 64'(vout), 64'd0);
        do_flush();

        // Two plain instructions: null postfix, pop one, second waits.
        rdy_in = 1'b0;
        push_word(w_add, 32'h0);
        push_word(w_xor, 32'h5);
        chk("np_valid", 64'(vout), 64'd1);
        chk("np_ir", 64'(ir), 64'(w_add));
        chk("np_pc", 64'(pc_out), 64'h0);
        chk("np_pfx_null", 64'(pfx), 64'd0);
        rdy_in = 1'b1;
        step();
        rdy_in = 1'b0;
        chk("np_count", 64'(dut.count_q), 64'd1);
        chk("np_hold_valid", 64'(vout), 64'd0);
        push_word(w_add, 32'hA);
        chk("np_xor_valid", 64'(vout), 64'd1);
        chk("np_xor_ir", 64'(ir), 64'(w_xor));
        chk("np_xor_pc", 64'(pc_out), 64'h5);
        do_flush();

        // Leading postfix is dropped with a single orphan pulse.
        push_word(w_pfx, 32'h20);
        chk("orph_valid", 64'(vout), 64'd0);
        chk("orph_pre", 64'(orphan), 64'd0);
        step();
        chk("orph_pulse", 64'(orphan), 64'd1);
        chk("orph_count", 64'(dut.count_q), 64'd0);
        step();
        chk("orph_clear", 64'(orphan), 64'd0);

        // Fill, reject a fifth word, then concurrent pop and push.
        rdy_in = 1'b0;
        for (int i = 0; i < 4; i++) push_word(w_add, 32'h40 + 32'(i));
        chk("full_ready", 64'(rdy_out), 64'd0);
        chk("full_count", 64'(dut.count_q), 64'd4);
        push_word(w_xor, 32'h44);
        chk("full_reject", 64'(dut.count_q), 64'd4);
        chk("full_hold_pc", 64'(pc_out), 64'h40);
        rdy_in = 1'b1; word = w_xor; pc = 32'h45; vin = 1'b1;
        step();
        chk("full_pop_only", 64'(dut.count_q), 64'd3);
        step();
        vin = 1'b0;
        chk("full_pushpop", 64'(dut.count_q), 64'd3);
        chk("full_head_pc", 64'(pc_out), 64'h42);
        step();
        chk("full_drain_pc", 64'(pc_out), 64'h43);
        chk("full_drain_ir", 64'(ir), 64'(w_add));
        step();
        chk("full_tail_count", 64'(dut.count_q), 64'd1);
        chk("full_tail_pc", 64'(pc_out), 64'h45);
        do_flush();

        // Flush with three words queued and a word on the input.
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) push_word(w_add, 32'h60 + 32'(i));
        flush = 1'b1; word = w_xor; pc = 32'h63; vin = 1'b1;
        #1;
        chk("fl_valid", 64'(vout), 64'd0);
        chk("fl_ready", 64'(rdy_out), 64'd0);
        step();
        flush = 1'b0; vin = 1'b0;
        #1;
        chk("fl_count", 64'(dut.count_q), 64'd0);
        chk("fl_valid_after", 64'(vout), 64'd0);
        push_word(w_addi, 32'h70);
        push_word(w_add, 32'h71);
        chk("fl_new_pc", 64'(pc_out), 64'h70);
        chk("fl_new_ir", 64'(ir), 64'(w_addi));

        // Asynchronous reset mid-stream.
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", 64'(vout), 64'd0);
        chk("ar_count", 64'(dut.count_q), 64'd0);
        #1 rst_n = 1'b1;
        step();
        chk("ar_ready", 64'(rdy_out), 64'd1);
        chk("ar_count_after", 64'(dut.count_q), 64'd0);
        chk("ar_valid_after", 64'(vout), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
